xbar_sched: RTL and testbench

//  Shares one pipelined Batcher sort/permute network among NREQ requesters. Round-robin arbitrates

---
 rtl/xbar_pkg.sv | 19 +
 rtl/xbar_rr_arbiter.sv | 61 ++++++
 rtl/xbar_sched.sv | 162 ++++++++++++++++
 tb/tb_xbar_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared definitions for the crossbar scheduler slice.
//   - XBAR_SCHED_* : default parameter values for xbar_sched
//   - sched_id_t   : requester index type at the default requester count
//   - lane_t / data_vec_t / tag_vec_t : lane and whole-vector types at defaults
package xbar_pkg;

    localparam int XBAR_SCHED_NREQ       = 4;
    localparam int XBAR_SCHED_SIZE       = 32;
    localparam int XBAR_SCHED_DWIDTH     = 16;
    localparam int XBAR_SCHED_LATENCY    = 14;
    localparam int XBAR_SCHED_FIFO_DEPTH = 4;
    localparam int XBAR_SCHED_TAGW       = $clog2(XBAR_SCHED_SIZE);

    typedef logic [$clog2(XBAR_SCHED_NREQ)-1:0]                sched_id_t;
    typedef logic [XBAR_SCHED_DWIDTH-1:0]                      lane_t;
    typedef logic [XBAR_SCHED_SIZE*XBAR_SCHED_DWIDTH-1:0]      data_vec_t;
    typedef logic [XBAR_SCHED_SIZE*XBAR_SCHED_TAGW-1:0]        tag_vec_t;

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst     : clock, synchronous active-high reset
//   req_i        : request vector (already qualified by the caller)
//   advance_i    : move the pointer to the granted index this cycle
//   grant_o      : one-hot combinational grant
//   grant_idx_o  : binary index of the grant (0 when no grant)
// The search starts one past the last granted index, so after reset
// (pointer = NREQ-1) requester 0 has first priority.
module xbar_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic                     advance_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [$clog2(NREQ)-1:0]  grant_idx_o
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;
    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDW'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = grant_idx_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/xbar_sched.sv
// Scheduler sharing one pipelined sort/permute network among NREQ requesters.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake, req_ready is a one-hot grant
//   req_data/req_shift   : flattened per-requester lane data and shift tags
//   bt_din/bt_shift      : registered vectors towards the network
//   bt_dout              : network output, LATENCY cycles after bt_din
//   rsp_valid/rsp_ready  : result handshake (first-word-fall-through FIFO head)
//   rsp_id/rsp_data      : requester index and result vector
//   inflight             : transfers issued and not yet popped
// The network cannot stall, so a transfer is only issued while a FIFO slot is
// reserved for it (credit); a result arriving from the network always fits.
module xbar_sched
    import xbar_pkg::*;
#(
    parameter int NREQ       = XBAR_SCHED_NREQ,
    parameter int SIZE       = XBAR_SCHED_SIZE,
    parameter int DWIDTH     = XBAR_SCHED_DWIDTH,
    parameter int LATENCY    = XBAR_SCHED_LATENCY,
    parameter int FIFO_DEPTH = XBAR_SCHED_FIFO_DEPTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    output logic [NREQ-1:0]                         req_ready,
    input  logic [NREQ*SIZE*DWIDTH-1:0]             req_data,
    input  logic [NREQ*SIZE*$clog2(SIZE)-1:0]       req_shift,
    output logic [SIZE*DWIDTH-1:0]                  bt_din,
    output logic [SIZE*$clog2(SIZE)-1:0]            bt_shift,
    input  logic [SIZE*DWIDTH-1:0]                  bt_dout,
    output logic                                    rsp_valid,
    input  logic                                    rsp_ready,
    output logic [$clog2(NREQ)-1:0]                 rsp_id,
    output logic [SIZE*DWIDTH-1:0]                  rsp_data,
    output logic [$clog2(LATENCY+FIFO_DEPTH+1)-1:0] inflight
);
    localparam int TAGW = $clog2(SIZE);
    localparam int IDW  = $clog2(NREQ);
    localparam int VW   = SIZE * DWIDTH;
    localparam int TW   = SIZE * TAGW;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IFW  = $clog2(LATENCY + FIFO_DEPTH + 1);

    logic [NREQ-1:0] arb_req, grant;
    logic [IDW-1:0]  grant_idx;
    logic            issue, pop, push;

    logic [CW-1:0]   credit_q, credit_d;
    logic [IFW-1:0]  inflight_q, inflight_d;
    logic [VW-1:0]   bt_din_q, bt_din_d;
    logic [TW-1:0]   bt_shift_q, bt_shift_d;

    // Delay line: stage 0 is aligned with bt_din, stage LATENCY with bt_dout.
    logic [LATENCY:0] dl_valid_q;
    logic [IDW-1:0]   dl_id_q [LATENCY+1];

    logic [VW-1:0]   fifo_data_q [FIFO_DEPTH];
    logic [IDW-1:0]  fifo_id_q   [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Grants are suppressed during reset and whenever no FIFO slot is free.
    assign arb_req = (credit_q != '0 && !rst) ? req_valid : '0;

    xbar_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (arb_req),
        .advance_i   (issue),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign issue     = |grant;
    assign req_ready = grant;
    assign push      = dl_valid_q[LATENCY];
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        bt_din_d   = '0;
        bt_shift_d = '0;
        if (issue) begin
            bt_din_d   = req_data[int'(grant_idx)*VW +: VW];
            bt_shift_d = req_shift[int'(grant_idx)*TW +: TW];
        end
    end

    always_comb begin
        credit_d   = credit_q;
        inflight_d = inflight_q;
        if (issue && !pop) begin
            credit_d   = credit_q - 1'b1;
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && pop) begin
            credit_d   = credit_q + 1'b1;
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q   <= CW'(FIFO_DEPTH);
            inflight_q <= '0;
            bt_din_q   <= '0;
            bt_shift_q <= '0;
            dl_valid_q <= '0;
        end else begin
            credit_q   <= credit_d;
            inflight_q <= inflight_d;
            bt_din_q   <= bt_din_d;
            bt_shift_q <= bt_shift_d;
            dl_valid_q <= {dl_valid_q[LATENCY-1:0], issue};
        end
    end

    // IDs carry no reset: only the valid bits decide whether a stage matters.
    always_ff @(posedge clk) begin
        dl_id_q[0] <= grant_idx;
        for (int k = 1; k <= LATENCY; k++) begin
            dl_id_q[k] <= dl_id_q[k-1];
        end
    end

    // FIFO storage; a push can never hit a full FIFO because of the credits.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= bt_dout;
            fifo_id_q[wr_ptr_q]   <= dl_id_q[LATENCY];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Head is presented directly; outputs read zero while the FIFO is empty.
    assign rsp_valid = (count_q != '0);
    assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]   : '0;
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bt_din    = bt_din_q;
    assign bt_shift  = bt_shift_q;
    assign inflight  = inflight_q;

endmodule

// File: tb/tb_xbar_sched.sv
module tb_xbar_sched;
    localparam int NREQ       = 4;
    localparam int SIZE       = 32;
    localparam int DWIDTH     = 16;
    localparam int LATENCY    = 14;
    localparam int FIFO_DEPTH = 4;
    localparam int TAGW       = $clog2(SIZE);
    localparam int IDW        = $clog2(NREQ);
    localparam int VW         = SIZE * DWIDTH;
    localparam int TW         = SIZE * TAGW;
    localparam int IFW        = $clog2(LATENCY + FIFO_DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*VW-1:0]     req_data;
    logic [NREQ*TW-1:0]     req_shift;
    logic [VW-1:0]          bt_din;
    logic [TW-1:0]          bt_shift;
    logic [VW-1:0]          bt_dout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [VW-1:0]          rsp_data;
    logic [IFW-1:0]         inflight;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    xbar_sched #(
        .NREQ(NREQ), .SIZE(SIZE), .DWIDTH(DWIDTH),
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift),
        .bt_din(bt_din), .bt_shift(bt_shift), .bt_dout(bt_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .inflight(inflight)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Network stand-in: each lane gets its shift tag added, LATENCY cycles later.
    function automatic logic [VW-1:0] net_fn(input logic [VW-1:0] d, input logic [TW-1:0] s);
        logic [VW-1:0] r;
        for (int j = 0; j < SIZE; j++)
            r[j*DWIDTH +: DWIDTH] = d[j*DWIDTH +: DWIDTH] + DWIDTH'(s[j*TAGW +: TAGW]);
        return r;
    endfunction

    logic [VW-1:0] net_pipe [LATENCY];
    always @(posedge clk) begin
        net_pipe[0] <= net_fn(bt_din, bt_shift);
        for (int k = 1; k < LATENCY; k++) net_pipe[k] <= net_pipe[k-1];
    end
    assign bt_dout = net_pipe[LATENCY-1];

    // Scoreboard: the reference arbiter/credit model pushes expected results at grant time.
    typedef struct {
        logic [IDW-1:0] id;
        logic [VW-1:0]  data;
        int             due;
    } exp_t;
    exp_t exp_q[$];
    int   m_credits = FIFO_DEPTH;
    int   m_ptr     = NREQ - 1;
    int   m_inflight = 0;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        int              gi;
        logic            erv;
        exp_t            e;
        eg = '0;
        gi = -1;
        if (rst) begin
            exp_q.delete();
            m_credits  = FIFO_DEPTH;
            m_ptr      = NREQ - 1;
            m_inflight = 0;
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL grant_in_reset cyc=%0d got=%b want=0", cyc, req_ready);
            end
        end else begin
            if (m_credits > 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_ptr + k) % NREQ;
                    if (gi < 0 && req_valid[idx]) gi = idx;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            erv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            checks++;
            if (req_ready !== eg) begin
                failures++;
                $display("FAIL sb_grant cyc=%0d got=%b want=%b", cyc, req_ready, eg);
            end
            checks++;
            if (rsp_valid !== erv) begin
                failures++;
                $display("FAIL sb_rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, erv);
            end
            checks++;
            if (inflight !== IFW'(m_inflight)) begin
                failures++;
                $display("FAIL sb_inflight cyc=%0d got=%0d want=%0d", cyc, inflight, m_inflight);
            end
            if (erv && rsp_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (rsp_id !== e.id || rsp_data !== e.data) begin
                    failures++;
                    $display("FAIL sb_rsp cyc=%0d id got=%0d want=%0d data_lane0 got=%h want=%h",
                             cyc, rsp_id, e.id, rsp_data[DWIDTH-1:0], e.data[DWIDTH-1:0]);
                end else begin
                    $display("rsp cyc=%0d id=%0d lane0=%h", cyc, rsp_id, rsp_data[DWIDTH-1:0]);
                end
                m_credits++;
                m_inflight--;
            end
            if (gi >= 0) begin
                e.id   = IDW'(gi);
                e.data = net_fn(req_data[gi*VW +: VW], req_shift[gi*TW +: TW]);
                e.due  = cyc + LATENCY + 2;
                exp_q.push_back(e);
                $display("grant cyc=%0d req=%0d", cyc, gi);
                m_credits--;
                m_inflight++;
                m_ptr = gi;
            end
        end
    end

    task automatic load_req(input int r, input int seed, input bit zero_shift);
        for (int j = 0; j < SIZE; j++) begin
            req_data[r*VW + j*DWIDTH +: DWIDTH] = DWIDTH'(seed * 64 + j);
            req_shift[r*TW + j*TAGW +: TAGW]    = zero_shift ? '0 : TAGW'((j + seed) % SIZE);
        end
    endtask

    task automatic drain();
        int c;
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || inflight !== '0 || rsp_id !== '0 ||
            rsp_data !== '0 || bt_din !== '0 || bt_shift !== '0) begin
            failures++;
            $display("FAIL reset_state got v=%b infl=%0d id=%0d din0=%h want all zero",
                     rsp_valid, inflight, rsp_id, bt_din[DWIDTH-1:0]);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int g, r, c;
        logic [VW-1:0] want;
        load_req(0, 0, 1'b1);
        for (int j = 0; j < SIZE; j++) want[j*DWIDTH +: DWIDTH] = DWIDTH'(j);
        g = -1;
        r = -1;
        @(posedge clk); #1;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        for (c = 0; c < 10 && g < 0; c++) begin
            @(negedge clk);
            if (req_ready[0]) g = cyc;
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (c = 0; c < 40 && r < 0; c++) begin
            @(negedge clk);
            if (rsp_valid) r = cyc;
        end
        checks++;
        if (g < 0 || r < 0 || r - g != LATENCY + 2) begin
            failures++;
            $display("FAIL single_latency got=%0d want=%0d", r - g, LATENCY + 2);
        end
        checks++;
        if (rsp_id !== '0 || rsp_data !== want) begin
            failures++;
            $display("FAIL single_data id got=%0d want=0 lane1 got=%h want=%h",
                     rsp_id, rsp_data[2*DWIDTH-1:DWIDTH], want[2*DWIDTH-1:DWIDTH]);
        end
        drain();
    endtask

    task automatic test_all_rr();
        int n;
        for (int i = 0; i < NREQ; i++) load_req(i, i + 1, 1'b0);
        req_valid = '1;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 120 && n < 8; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                checks++;
                if (req_ready !== (NREQ'(1) << ((1 + n) % NREQ))) begin
                    failures++;
                    $display("FAIL rr_order n=%0d got=%b want=%b", n, req_ready,
                             NREQ'(1) << ((1 + n) % NREQ));
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL rr_count got=%0d want=8", n);
        end
        drain();
    endtask

    task automatic test_backpressure_refill();
        int ng, np;
        load_req(0, 7, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready[0]) ng++;
        end
        checks++;
        if (ng != FIFO_DEPTH || inflight !== IFW'(FIFO_DEPTH) || req_ready !== '0) begin
            failures++;
            $display("FAIL credit_stall grants got=%0d want=%0d inflight got=%0d want=%0d",
                     ng, FIFO_DEPTH, inflight, FIFO_DEPTH);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        ng = 0;
        np = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_ready[0]) ng++;
            if (rsp_valid && rsp_ready) np++;
        end
        checks++;
        if (ng != 4 || np != 4) begin
            failures++;
            $display("FAIL refill grants got=%0d want=4 pops got=%0d want=4", ng, np);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int nv;
        for (int i = 0; i < NREQ; i++) load_req(i, i + 9, 1'b0);
        rsp_ready = 1'b1;
        req_valid = '1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || inflight !== '0) begin
            failures++;
            $display("FAIL reset_flush v got=%b want=0 inflight got=%0d want=0", rsp_valid, inflight);
        end
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid) nv++;
        end
        checks++;
        if (nv != 0) begin
            failures++;
            $display("FAIL stale_rsp got=%0d want=0", nv);
        end
    endtask

    task automatic test_drop_valid();
        int ng;
        load_req(0, 3, 1'b0);
        load_req(1, 4, 1'b0);
        load_req(2, 5, 1'b0);
        load_req(3, 6, 1'b0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        ng = 0;
        for (int c = 0; c < 40 && ng < FIFO_DEPTH; c++) begin
            @(negedge clk);
            if (req_ready[0]) ng++;
        end
        checks++;
        if (ng != FIFO_DEPTH) begin
            failures++;
            $display("FAIL fill_grants got=%0d want=%0d", ng, FIFO_DEPTH);
        end
        @(posedge clk); #1;
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL no_credit_grant got=%b want=0000", req_ready);
            end
        end
        drain();
        req_valid = 4'b1110;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL ptr_kept got=%b want=0010", req_ready);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data  = '0;
        req_shift = '0;
        test_reset();
        test_single();
        test_all_rr();
        test_backpressure_refill();
        test_reset_midflight();
        test_drop_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
